// File: rtl/rtlfuzz_commit_monitor.sv
// rtlfuzz_commit_monitor
// Watches the per-cycle retirement trace and keeps shadow copies of gp (x3)
// and a0 (x10). It raises a sticky end-of-test flag on one of two conditions:
// a `j .` self-loop retiring twice at the same PC, or an `ecall` retiring
// while gp holds the pass value.
//
// Trace semantics: `valid` qualifies pc/inst/hartid for exactly one cycle.
// There is no back-pressure, so the monitor must accept every retirement.
// The long-latency write-back port (mstatus[6:1] plus wdata) is qualified
// by mstatus[1] alone and is independent of `valid`.
module rtlfuzz_commit_monitor #(
    parameter int unsigned              PC_W     = 40,
    parameter int unsigned              XLEN     = 64,
    parameter int unsigned              HARTID_W = 1,
    parameter logic [XLEN-1:0]          PASS_GP  = {{(XLEN-1){1'b0}}, 1'b1}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid,
    input  logic [HARTID_W-1:0] hartid,
    input  logic [PC_W-1:0]     pc,
    input  logic [31:0]         inst,
    input  logic [XLEN-1:0]     wdata,
    input  logic [6:0]          mstatus,
    output logic                finish
);

    localparam logic [4:0]  REG_GP   = 5'd3;
    localparam logic [4:0]  REG_A0   = 5'd10;
    localparam logic [31:0] INST_JSELF = 32'h0000_006f;
    localparam logic [31:0] INST_ECALL = 32'h0000_0073;

    // hartid is carried for trace completeness only; nothing depends on it.
    logic unused_hartid;
    assign unused_hartid = ^hartid;

    logic [XLEN-1:0] gp_q, gp_d;
    logic [XLEN-1:0] a0_q, a0_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic            last_vld_q, last_vld_d;
    logic            finish_q, finish_d;

    logic [4:0] rd;
    logic [4:0] ll_rd;
    logic       ll_we;
    logic       writes_rd;
    logic       ret_we;
    logic       trig_self_loop;
    logic       trig_pass_ecall;

    assign rd    = inst[11:7];
    assign ll_rd = mstatus[6:2];
    assign ll_we = mstatus[1];

    // Decode which uncompressed opcodes architecturally write rd.
    always_comb begin
        writes_rd = 1'b0;
        if (inst[1:0] == 2'b11) begin
            unique case (inst[6:0])
                7'b0110111,                 // lui
                7'b0010111,                 // auipc
                7'b1101111,                 // jal
                7'b1100111,                 // jalr
                7'b0000011,                 // loads
                7'b0010011,                 // op-imm
                7'b0110011,                 // op
                7'b0011011,                 // op-imm-32
                7'b0111011,                 // op-32
                7'b0101111: writes_rd = 1'b1; // amo
                7'b1110011: writes_rd = (inst[14:12] != 3'b000); // csr ops only
                default:    writes_rd = 1'b0;
            endcase
        end
    end

    // Retirement write is suppressed while the data is still in flight;
    // it shows up later on the long-latency port instead.
    assign ret_we = valid && writes_rd && !mstatus[0];

    // Triggers look at the registered gp value, not at this cycle's update.
    assign trig_self_loop  = valid && (inst == INST_JSELF) && last_vld_q
                             && (pc == last_pc_q);
    assign trig_pass_ecall = valid && (inst == INST_ECALL) && (gp_q == PASS_GP);

    // Next-state for shadows, last-PC tracker and the sticky flag.
    // The long-latency write is applied last so it wins a same-register clash.
    always_comb begin
        gp_d       = gp_q;
        a0_d       = a0_q;
        last_pc_d  = last_pc_q;
        last_vld_d = last_vld_q;
        finish_d   = finish_q;

        if (ret_we && (rd == REG_GP)) gp_d = wdata;
        if (ret_we && (rd == REG_A0)) a0_d = wdata;
        if (ll_we && (ll_rd == REG_GP)) gp_d = wdata;
        if (ll_we && (ll_rd == REG_A0)) a0_d = wdata;

        if (valid) begin
            last_pc_d  = pc;
            last_vld_d = 1'b1;
        end

        if (trig_self_loop || trig_pass_ecall) finish_d = 1'b1;
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gp_q       <= '0;
            a0_q       <= '0;
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            gp_q       <= gp_d;
            a0_q       <= a0_d;
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
            finish_q   <= finish_d;
        end
    end

    assign finish = finish_q;

endmodule

// File: tb/tb_rtlfuzz_commit_monitor.sv
// Bench for rtlfuzz_commit_monitor: a table of directed vectors, a hand-written
// asynchronous-reset sequence, then random traffic against a reference model.
module tb_rtlfuzz_commit_monitor;

    localparam int PC_W = 40;
    localparam int XLEN = 64;

    localparam logic [31:0] I_JSELF  = 32'h0000_006f;
    localparam logic [31:0] I_ECALL  = 32'h0000_0073;
    localparam logic [31:0] I_LI_GP  = 32'h0010_0193;  // addi gp,x0,1
    localparam logic [31:0] I_LI_A0  = 32'h0010_0513;  // addi a0,x0,1
    localparam logic [31:0] I_LD_GP  = 32'h0001_3183;  // ld gp,0(sp)
    localparam logic [31:0] I_CLI_GP = 32'h0000_4185;  // c.li gp,1
    localparam logic [31:0] I_NOP    = 32'h0000_0013;
    localparam logic [31:0] I_CSR_GP = 32'h3000_21f3;  // csrrs gp,mstatus,x0
    localparam logic [39:0] P0 = 40'h00_8000_0100;
    localparam logic [39:0] P1 = 40'h00_8000_0104;
    localparam logic [39:0] P2 = 40'h00_8000_0108;

    // ---------------- clock / reset / DUT ----------------
    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            valid = 1'b0;
    logic [0:0]      hartid = '0;
    logic [PC_W-1:0] pc = '0;
    logic [31:0]     inst = '0;
    logic [XLEN-1:0] wdata = '0;
    logic [6:0]      mstatus = '0;
    logic            finish;

    always #5 clock = ~clock;

    rtlfuzz_commit_monitor dut (
        .clock  (clock),
        .reset  (reset),
        .valid  (valid),
        .hartid (hartid),
        .pc     (pc),
        .inst   (inst),
        .wdata  (wdata),
        .mstatus(mstatus),
        .finish (finish)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got finish=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge, then let the rising edge happen
    // and return 1 time unit after it so outputs can be sampled.
    task automatic apply(input logic r, input logic v, input logic [39:0] p,
                         input logic [31:0] i, input logic [63:0] w,
                         input logic [6:0] m);
        @(negedge clock);
        reset   = r;
        valid   = v;
        pc      = p;
        inst    = i;
        wdata   = w;
        mstatus = m;
        hartid  = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Whole architectural register file; only x3 feeds a decision.
    logic [63:0] m_reg [32];
    logic [39:0] m_last_pc;
    bit          m_last_vld;
    bit          m_fin;
    logic        exp_q[$];

    function automatic bit m_writes_rd(input logic [31:0] i);
        logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03,
                                 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h2f};
        if (i[1:0] != 2'b11) return 1'b0;
        if (i[6:0] == 7'h73) return i[14:12] != 3'd0;
        foreach (ops[k]) if (ops[k] == i[6:0]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [39:0] p,
                              input logic [31:0] i, input logic [63:0] w,
                              input logic [6:0] m);
        bit trig;
        if (!r) begin
            foreach (m_reg[k]) m_reg[k] = '0;
            m_last_pc  = '0;
            m_last_vld = 1'b0;
            m_fin      = 1'b0;
        end else begin
            trig = v && ((i == I_JSELF && m_last_vld && p == m_last_pc) ||
                         (i == I_ECALL && m_reg[3] == 64'd1));
            if (v && m_writes_rd(i) && !m[0] && i[11:7] != 5'd0) m_reg[i[11:7]] = w;
            if (m[1] && m[6:2] != 5'd0) m_reg[m[6:2]] = w;  // in-flight data lands last
            if (v) begin
                m_last_pc  = p;
                m_last_vld = 1'b1;
            end
            m_fin = m_fin | trig;
        end
        exp_q.push_back(m_fin);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst_n;
        logic        v;
        logic [39:0] pc;
        logic [31:0] inst;
        logic [63:0] wdata;
        logic [6:0]  ms;
        logic        exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [39:0] p,
                                input logic [31:0] i, input logic [63:0] w,
                                input logic [6:0] m, input logic e, input string n);
        vec_t t;
        t.rst_n = r; t.v = v; t.pc = p; t.inst = i; t.wdata = w;
        t.ms = m; t.exp = e; t.name = n;
        return t;
    endfunction

    initial begin
        // reset held while self-loops retire
        tbl.push_back(mk(0, 1, P0, I_JSELF, 0, 0, 0, "reset_hold0"));
        tbl.push_back(mk(0, 1, P0, I_JSELF, 0, 0, 0, "reset_hold1"));
        tbl.push_back(mk(0, 1, P0, I_JSELF, 0, 0, 0, "reset_hold2"));
        // self-loop with idle gap
        tbl.push_back(mk(1, 1, P0, I_JSELF, 0, 0, 0, "jself_first"));
        tbl.push_back(mk(1, 0, P2, I_JSELF, 0, 0, 0, "jself_idle0"));
        tbl.push_back(mk(1, 0, P1, I_ECALL, 0, 0, 0, "jself_idle1"));
        tbl.push_back(mk(1, 1, P0, I_JSELF, 0, 0, 1, "jself_second"));
        tbl.push_back(mk(1, 1, P1, I_NOP,   0, 0, 1, "jself_sticky"));
        // self-loop at a different PC
        tbl.push_back(mk(0, 0, 0,  0,       0, 0, 0, "rst_a"));
        tbl.push_back(mk(1, 1, P0, I_JSELF, 0, 0, 0, "jdiff_first"));
        tbl.push_back(mk(1, 1, P1, I_JSELF, 0, 0, 0, "jdiff_second"));
        tbl.push_back(mk(1, 0, 0,  0,       0, 0, 0, "jdiff_idle"));
        // pass ecall
        tbl.push_back(mk(1, 1, P2, I_LI_GP, 1, 0, 0, "ecall_li1"));
        tbl.push_back(mk(1, 1, P1, I_ECALL, 0, 0, 1, "ecall_pass"));
        tbl.push_back(mk(0, 0, 0,  0,       0, 0, 0, "rst_b"));
        tbl.push_back(mk(1, 1, P2, I_LI_GP, 3, 0, 0, "ecall_li3"));
        tbl.push_back(mk(1, 1, P1, I_ECALL, 0, 0, 0, "ecall_gp3"));
        // deferred load
        tbl.push_back(mk(1, 1, P0, I_LD_GP, 1, 7'b00000_0_1, 0, "ld_defer"));
        tbl.push_back(mk(1, 1, P1, I_ECALL, 0, 0,             0, "ld_early_ecall"));
        tbl.push_back(mk(1, 0, 0,  0,       1, {5'd3, 2'b10}, 0, "ld_llwrite"));
        tbl.push_back(mk(1, 1, P2, I_ECALL, 0, 0,             1, "ld_ecall"));
        // collision on gp, then split gp/a0 writes in one cycle
        tbl.push_back(mk(0, 0, 0,  0,       0, 0, 0, "rst_c"));
        tbl.push_back(mk(1, 1, P0, I_LI_GP, 5, {5'd3, 2'b10},  0, "coll_gp"));
        tbl.push_back(mk(1, 1, P1, I_ECALL, 0, 0,              0, "coll_ecall"));
        tbl.push_back(mk(1, 1, P2, I_LI_GP, 1, {5'd10, 2'b10}, 0, "split_gp_a0"));
        tbl.push_back(mk(1, 1, P0, I_ECALL, 0, 0,              1, "split_ecall"));
        // compressed instructions
        tbl.push_back(mk(0, 0, 0,  0,        0, 0, 0, "rst_d"));
        tbl.push_back(mk(1, 1, P0, I_CLI_GP, 1, 0, 0, "cli_gp"));
        tbl.push_back(mk(1, 1, P1, I_ECALL,  0, 0, 0, "cli_ecall"));
        tbl.push_back(mk(1, 1, P0, I_JSELF,  0, 0, 0, "cpc_j1"));
        tbl.push_back(mk(1, 1, P2, I_CLI_GP, 0, 0, 0, "cpc_c"));
        tbl.push_back(mk(1, 1, P0, I_JSELF,  0, 0, 0, "cpc_j2"));
        // a0 write leaves gp alone; csr write to gp counts
        tbl.push_back(mk(1, 1, P1, I_LI_A0,  1, 0, 0, "li_a0"));
        tbl.push_back(mk(1, 1, P2, I_ECALL,  0, 0, 0, "a0_ecall"));
        tbl.push_back(mk(1, 1, P0, I_CSR_GP, 1, 0, 0, "csr_gp"));
        tbl.push_back(mk(1, 1, P1, I_ECALL,  0, 0, 1, "csr_ecall"));

        repeat (2) @(posedge clock);
        foreach (tbl[k])
            begin
                apply(tbl[k].rst_n, tbl[k].v, tbl[k].pc, tbl[k].inst,
                      tbl[k].wdata, tbl[k].ms);
                check(tbl[k].name, finish, tbl[k].exp);
            end

        // ---- asynchronous reset mid-cycle ----
        apply(0, 0, 0, 0, 0, 0);
        apply(1, 1, P0, I_JSELF, 0, 0);
        apply(1, 1, P0, I_JSELF, 0, 0);
        check("async_pre", finish, 1'b1);
        #2 reset = 1'b0;
        #1 check("async_drop", finish, 1'b0);
        apply(0, 0, 0, 0, 0, 0);
        check("async_held", finish, 1'b0);

        // ---- random traffic against the model ----
        apply(0, 0, 0, 0, 0, 0);
        model_step(0, 0, 0, 0, 0, 0);
        void'(exp_q.pop_front());
        for (int n = 0; n < 3000; n++) begin
            logic        r, v;
            logic [39:0] p;
            logic [31:0] i;
            logic [63:0] w;
            logic [6:0]  m;
            logic [4:0]  llr;
            r = ($urandom_range(0, 149) != 0);
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: p = P0;
                1: p = P1;
                default: p = P2;
            endcase
            case ($urandom_range(0, 9))
                0, 1: i = I_JSELF;
                2, 3: i = I_ECALL;
                4: i = I_LI_GP;
                5: i = I_LD_GP;
                6: i = I_LI_A0;
                7: i = I_CLI_GP;
                8: i = I_CSR_GP;
                default: i = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: w = 64'd0;
                1, 2: w = 64'd1;
                3: w = 64'd3;
                default: w = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 2))
                0: llr = 5'd3;
                1: llr = 5'd10;
                default: llr = 5'($urandom_range(0, 31));
            endcase
            m = {llr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            model_step(r, v, p, i, w, m);
            apply(r, v, p, i, w, m);
            check($sformatf("rand_%0d", n), finish, exp_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
